cpu_run_ctrl: RTL

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_run_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: debounced step/mode pushbuttons drive a STEP/RUN FSM that issues single-cycle CPU clock enables.
// Define CPU_RUN_CTRL_HALT_DETECT_EN to add a HALT state entered when the CPU parks on a self-loop.
module cpu_run_ctrl #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int W_PC            = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            strobe,
   input  logic            key_step,
   input  logic            key_mode,
   input  logic [W_PC-1:0] cpu_pc,
   output logic            cpu_clk_en,
   output logic            mode_run,
   output logic            halted,
   output logic [15:0]     step_count
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef CPU_RUN_CTRL_HALT_DETECT_EN
   typedef enum logic [1:0] {STEP, RUN, HALT} state_t;
`else
   typedef enum logic [1:0] {STEP, RUN} state_t;
`endif

   logic [1:0] keyRaw;
   logic [1:0] pressVec;
   logic       stepPress;
   logic       modePress;
   logic       haltHit;

   state_t      state_q, state_d;
   logic        clkEn_q, clkEn_d;
   logic        modeRun_q;
   logic [15:0] count_q;

   assign keyRaw = {key_mode, key_step};

   // Each key: 2-flop synchronizer, then a counter of consecutive samples that differ from the accepted level.
   for (genvar k = 0; k < 2; k++) begin : gKey
      logic          sync1_q, sync2_q, level_q, press_q;
      logic [CW-1:0] cnt_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
         end else begin
            sync1_q <= keyRaw[k];
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
               cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
               level_q <= sync2_q;
               press_q <= sync2_q;
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end

      assign pressVec[k] = press_q;
   end

   assign stepPress = pressVec[0];
   assign modePress = pressVec[1];

`ifdef CPU_RUN_CTRL_HALT_DETECT_EN
   logic [W_PC-1:0] pc_q;
   logic            chk_q;
   logic            halted_q;

   assign haltHit = chk_q && (cpu_pc == pc_q) && (state_q != HALT);

   // PC is captured while the enable is high and compared one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= '0;
         chk_q    <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         if (clkEn_q) begin
            pc_q <= cpu_pc;
         end
         chk_q    <= clkEn_q;
         halted_q <= (state_d == HALT);
      end
   end

   assign halted = halted_q;
`else
   logic unusedPc;

   assign unusedPc = ^cpu_pc;
   assign haltHit  = 1'b0;
   assign halted   = 1'b0;
`endif

   // Mode press outranks everything else, so a coincident strobe or step is dropped.
   always_comb begin
      state_d = state_q;
      clkEn_d = 1'b0;
      if (modePress) begin
         state_d = (state_q == STEP) ? RUN : STEP;
`ifdef CPU_RUN_CTRL_HALT_DETECT_EN
      end else if (haltHit) begin
         state_d = HALT;
`endif
      end else begin
         case (state_q)
            STEP:    clkEn_d = stepPress & ~clkEn_q;
            RUN:     clkEn_d = strobe & ~clkEn_q;
            default: clkEn_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= STEP;
         clkEn_q   <= 1'b0;
         modeRun_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         clkEn_q   <= clkEn_d;
         modeRun_q <= (state_d == RUN);
         if (clkEn_q && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
         end
      end
   end

   assign cpu_clk_en = clkEn_q;
   assign mode_run   = modeRun_q;
   assign step_count = count_q;

endmodule
